// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer for the single-cycle CPU: gates progress via cpu_en, runs host
// commands (RUN, STEP, RUN_N, DUMP), stops on breakpoint or halt, streams the regfile out.
module cpu_run_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   input  logic             halt_req,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      cpu_pc,
   output logic             cpu_en,
   output logic [4:0]       rf_raddr,
   input  logic [31:0]      rf_rdata,
   output logic             dump_valid,
   input  logic             dump_ready,
   output logic [4:0]       dump_idx,
   output logic [31:0]      dump_data,
   output logic             busy,
   output logic [1:0]       stop_cause,
   output logic [31:0]      icount
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_RUN_N, S_DUMP} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [4:0]       dump_idx_q, dump_idx_d;
   logic             first_q, first_d;
   logic [1:0]       stop_cause_q, stop_cause_d;
   logic [31:0]      icount_q, icount_d;

   logic running;
   logic bp_hit;
   logic count_zero;
   logic cmd_fire;
   logic dump_fire;

   assign running    = (state_q == S_RUN) || (state_q == S_RUN_N);
   // Breakpoint is masked on the first cycle so a run can resume from bp_addr.
   assign bp_hit     = bp_en && (cpu_pc == bp_addr) && !first_q;
   assign count_zero = (state_q == S_RUN_N) && (remaining_q == CNT_ZERO);

   assign cmd_ready  = rst && (state_q == S_IDLE);
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign cpu_en     = rst && running && !halt_req && !bp_hit && !count_zero;
   // A halt aborts the dump without completing a handshake in that cycle.
   assign dump_valid = rst && (state_q == S_DUMP) && !halt_req;
   assign dump_fire  = dump_valid && dump_ready;
   assign busy       = rst && (state_q != S_IDLE);

   assign rf_raddr   = dump_idx_q;
   assign dump_idx   = dump_idx_q;
   assign dump_data  = rf_rdata;
   assign stop_cause = stop_cause_q;
   assign icount     = icount_q;

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      dump_idx_d   = dump_idx_q;
      first_d      = 1'b0;
      stop_cause_d = stop_cause_q;
      icount_d     = icount_q + {31'd0, cpu_en};

      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               stop_cause_d = 2'b00;
               case (cmd_op)
                  2'b00: begin
                     state_d = S_RUN;
                     first_d = 1'b1;
                  end
                  2'b01: begin
                     state_d     = S_RUN_N;
                     remaining_d = CNT_ONE;
                     first_d     = 1'b1;
                  end
                  2'b10: begin
                     state_d     = S_RUN_N;
                     remaining_d = cmd_arg;
                     first_d     = 1'b1;
                  end
                  default: begin
                     state_d    = S_DUMP;
                     dump_idx_d = 5'd0;
                  end
               endcase
            end
         end
         S_RUN: begin
            if (halt_req) begin
               state_d      = S_IDLE;
               stop_cause_d = 2'b11;
            end else if (bp_hit) begin
               state_d      = S_IDLE;
               stop_cause_d = 2'b10;
            end
         end
         S_RUN_N: begin
            if (halt_req) begin
               state_d      = S_IDLE;
               stop_cause_d = 2'b11;
            end else if (bp_hit) begin
               state_d      = S_IDLE;
               stop_cause_d = 2'b10;
            end else if (count_zero) begin
               state_d      = S_IDLE;
               stop_cause_d = 2'b01;
            end else begin
               remaining_d = remaining_q - CNT_ONE;
               if (remaining_q == CNT_ONE) begin
                  state_d      = S_IDLE;
                  stop_cause_d = 2'b01;
               end
            end
         end
         S_DUMP: begin
            if (halt_req) begin
               state_d      = S_IDLE;
               stop_cause_d = 2'b11;
            end else if (dump_fire) begin
               dump_idx_d = dump_idx_q + 5'd1;
               if (dump_idx_q == 5'd31) begin
                  state_d      = S_IDLE;
                  stop_cause_d = 2'b01;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         remaining_q  <= '0;
         dump_idx_q   <= 5'd0;
         first_q      <= 1'b0;
         stop_cause_q <= 2'b00;
         icount_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         dump_idx_q   <= dump_idx_d;
         first_q      <= first_d;
         stop_cause_q <= stop_cause_d;
         icount_q     <= icount_d;
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny PC/regfile stand-in for the CPU.
module tb_cpu_run_ctrl;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd_op = 2'b00;
   logic [CNT_W-1:0] cmd_arg = '0;
   logic             halt_req = 1'b0;
   logic             bp_en = 1'b0;
   logic [31:0]      bp_addr = 32'd0;
   logic [31:0]      cpu_pc;
   logic             cpu_en;
   logic [4:0]       rf_raddr;
   logic [31:0]      rf_rdata;
   logic             dump_valid;
   logic             dump_ready = 1'b0;
   logic [4:0]       dump_idx;
   logic [31:0]      dump_data;
   logic             busy;
   logic [1:0]       stop_cause;
   logic [31:0]      icount;

   logic [31:0] rf [32];
   logic        pc_load = 1'b0;
   logic [31:0] pc_load_val = 32'd0;
   logic [31:0] pc_q = 32'd0;

   int vec_cnt = 0;
   int err_cnt = 0;

   cpu_run_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(cpu_pc),
      .cpu_en(cpu_en), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
      .dump_data(dump_data), .busy(busy), .stop_cause(stop_cause), .icount(icount)
   );

   always #5 clk = ~clk;

   // CPU stand-in: PC advances one instruction per enabled cycle.
   always @(posedge clk) begin
      if (pc_load) pc_q <= pc_load_val;
      else if (cpu_en) pc_q <= pc_q + 32'd4;
   end
   assign cpu_pc   = pc_q;
   assign rf_rdata = rf[rf_raddr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic load_pc(input logic [31:0] val);
      pc_load     = 1'b1;
      pc_load_val = val;
      tick();
      pc_load     = 1'b0;
   endtask

   // Returns one cycle after the accepting edge (cycle T+1).
   task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] arg);
      cmd_op    = op;
      cmd_arg   = arg;
      cmd_valid = 1'b1;
      #1;
      check_vec("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic run_until_idle(input int limit, output int en_cyc, output int idle_at);
      en_cyc  = 0;
      idle_at = -1;
      for (int c = 1; c <= limit; c++) begin
         if (!busy) begin
            idle_at = c;
            break;
         end
         if (cpu_en) en_cyc++;
         tick();
      end
   endtask

   int          en_cyc;
   int          idle_at;
   int          exp_icount;
   int          exp_idx;
   int          xfers;
   logic        have_stall;
   logic [31:0] stall_data;
   logic [31:0] pc_start;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : (32'hA500_0000 ^ (i * 32'h0001_0203));

      // Reset
      tick();
      tick();
      check_vec("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check_vec("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
      rst = 1'b1;
      #1;
      check_vec("rst_busy", {31'd0, busy}, 32'd0);
      check_vec("rst_stop", {30'd0, stop_cause}, 32'd0);
      check_vec("rst_icount", icount, 32'd0);
      check_vec("rst_idx", {27'd0, dump_idx}, 32'd0);
      exp_icount = 0;

      // RUN_N 30 from 0x3000
      load_pc(32'h3000);
      issue(2'b10, 16'd30);
      run_until_idle(100, en_cyc, idle_at);
      exp_icount += 30;
      check_vec("runn_en_cycles", 32'(en_cyc), 32'd30);
      check_vec("runn_idle_at", 32'(idle_at), 32'd31);
      check_vec("runn_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_vec("runn_stop", {30'd0, stop_cause}, 32'd1);
      check_vec("runn_icount", icount, 32'(exp_icount));
      check_vec("runn_pc", cpu_pc, 32'h3000 + 32'd120);

      // STEP x3
      for (int s = 0; s < 3; s++) begin
         issue(2'b01, 16'd0);
         run_until_idle(10, en_cyc, idle_at);
         check_vec("step_en_cycles", 32'(en_cyc), 32'd1);
         check_vec("step_idle_at", 32'(idle_at), 32'd2);
         check_vec("step_stop", {30'd0, stop_cause}, 32'd1);
      end
      exp_icount += 3;
      check_vec("step_icount", icount, 32'(exp_icount));
      check_vec("step_pc", cpu_pc, 32'h3084);

      // Breakpoint at 0x300C
      load_pc(32'h3000);
      bp_en   = 1'b1;
      bp_addr = 32'h300C;
      issue(2'b00, 16'd0);
      run_until_idle(50, en_cyc, idle_at);
      exp_icount += 3;
      check_vec("bp_en_cycles", 32'(en_cyc), 32'd3);
      check_vec("bp_idle_at", 32'(idle_at), 32'd5);
      check_vec("bp_pc", cpu_pc, 32'h300C);
      check_vec("bp_stop", {30'd0, stop_cause}, 32'd2);
      check_vec("bp_icount", icount, 32'(exp_icount));

      // Resume from the breakpoint PC, then halt
      issue(2'b00, 16'd0);
      check_vec("resume_first_en", {31'd0, cpu_en}, 32'd1);
      check_vec("resume_stop_cleared", {30'd0, stop_cause}, 32'd0);
      tick();
      tick();
      halt_req = 1'b1;
      #1;
      check_vec("resume_halt_en", {31'd0, cpu_en}, 32'd0);
      tick();
      halt_req = 1'b0;
      exp_icount += 2;
      check_vec("resume_busy", {31'd0, busy}, 32'd0);
      check_vec("resume_stop", {30'd0, stop_cause}, 32'd3);
      check_vec("resume_pc", cpu_pc, 32'h3014);
      check_vec("resume_icount", icount, 32'(exp_icount));

      // Halt at cycle 7 after acceptance
      bp_en = 1'b0;
      issue(2'b00, 16'd0);
      for (int c = 0; c < 6; c++) tick();
      halt_req = 1'b1;
      #1;
      check_vec("halt_en", {31'd0, cpu_en}, 32'd0);
      tick();
      halt_req = 1'b0;
      exp_icount += 6;
      check_vec("halt_stop", {30'd0, stop_cause}, 32'd3);
      check_vec("halt_icount", icount, 32'(exp_icount));

      // Halt coinciding with a breakpoint hit
      pc_start = pc_q;
      bp_en    = 1'b1;
      bp_addr  = pc_start + 32'd8;
      issue(2'b00, 16'd0);
      tick();
      tick();
      check_vec("halt_bp_pc", cpu_pc, pc_start + 32'd8);
      halt_req = 1'b1;
      #1;
      check_vec("halt_bp_en", {31'd0, cpu_en}, 32'd0);
      tick();
      halt_req = 1'b0;
      bp_en    = 1'b0;
      exp_icount += 2;
      check_vec("halt_bp_stop", {30'd0, stop_cause}, 32'd3);
      check_vec("halt_bp_icount", icount, 32'(exp_icount));

      // DUMP with dump_ready high on odd cycles after acceptance
      issue(2'b11, 16'd0);
      exp_idx    = 0;
      xfers      = 0;
      idle_at    = -1;
      have_stall = 1'b0;
      stall_data = 32'd0;
      for (int c = 1; c <= 100; c++) begin
         dump_ready = c[0];
         #1;
         if (!busy) begin
            idle_at = c;
            break;
         end
         if (dump_ready) begin
            check_vec("dump_idx", {27'd0, dump_idx}, 32'(exp_idx));
            check_vec("dump_data", dump_data, rf[exp_idx]);
            if (have_stall) check_vec("dump_hold", dump_data, stall_data);
            exp_idx++;
            xfers++;
         end else begin
            check_vec("stall_idx", {27'd0, dump_idx}, 32'(exp_idx));
            stall_data = dump_data;
            have_stall = 1'b1;
         end
         tick();
      end
      check_vec("dump_xfers", 32'(xfers), 32'd32);
      check_vec("dump_idle_at", 32'(idle_at), 32'd64);
      check_vec("dump_stop", {30'd0, stop_cause}, 32'd1);
      check_vec("dump_icount", icount, 32'(exp_icount));

      // RUN_N with zero count
      issue(2'b10, 16'd0);
      check_vec("runn0_en", {31'd0, cpu_en}, 32'd0);
      check_vec("runn0_busy", {31'd0, busy}, 32'd1);
      tick();
      check_vec("runn0_idle", {31'd0, busy}, 32'd0);
      check_vec("runn0_stop", {30'd0, stop_cause}, 32'd1);
      check_vec("runn0_icount", icount, 32'(exp_icount));

      // Reset mid-DUMP at idx 10
      dump_ready = 1'b1;
      issue(2'b11, 16'd0);
      for (int c = 0; c < 10; c++) tick();
      check_vec("mid_dump_idx", {27'd0, dump_idx}, 32'd10);
      rst = 1'b0;
      #1;
      check_vec("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
      check_vec("mid_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b1;
      #1;
      check_vec("post_rst_idx", {27'd0, dump_idx}, 32'd0);
      check_vec("post_rst_busy", {31'd0, busy}, 32'd0);
      check_vec("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
      check_vec("post_rst_icount", icount, 32'd0);
      check_vec("post_rst_stop", {30'd0, stop_cause}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/debug sequencer for the single-cycle CPU. It gates CPU progress through a clock-enable, executes host commands (free run, single step, run N cycles, register dump) and stops on a PC breakpoint or an external halt. It streams the register file out over a valid/ready port, one register per transfer. It sits between the bench/host and the `CPU` top, and drives the regfile's debug read port.

## Interface
Parameters:
- CNT_W, 16, width of the RUN_N cycle-count argument

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  2  00 RUN, 01 STEP, 10 RUN_N, 11 DUMP
- cmd_arg  in  CNT_W  cycle count for RUN_N; ignored otherwise
- halt_req  in  1  abort the current RUN/RUN_N/DUMP
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- cpu_pc  in  32  current CPU PC (registered inside the CPU)
- cpu_en  out  1  CPU advance enable; the CPU updates PC, regfile and memory only when high
- rf_raddr  out  5  regfile debug read address
- rf_rdata  in  32  regfile debug read data (combinational)
- dump_valid  out  1  dump word available
- dump_ready  in  1  sink accepts the dump word
- dump_idx  out  5  register index of dump_data
- dump_data  out  32  register value
- busy  out  1  state != IDLE
- stop_cause  out  2  00 none, 01 count done/step done, 10 breakpoint, 11 halt_req
- icount  out  32  number of cycles with cpu_en=1

## Operation
- States: IDLE, RUN, RUN_N, DUMP. STEP is RUN_N with a count of 1.
- IDLE:
  - cmd_ready=1, cpu_en=0.
  - A command is accepted when cmd_valid && cmd_ready.
  - RUN → RUN. STEP → RUN_N with remaining=1. RUN_N → RUN_N with remaining=cmd_arg. DUMP → DUMP with idx=0.
  - RUN_N with cmd_arg=0 goes to RUN_N, issues no cpu_en, returns to IDLE next cycle with stop_cause=01.
  - halt_req in IDLE is ignored.
- first flag: set on entry to RUN or RUN_N, cleared after the first cycle in that state.
- bp_hit = bp_en && cpu_pc==bp_addr && !first. The breakpoint is ignored on the first cycle of a command, so a run can resume from a breakpoint PC.
- RUN:
  - cpu_en = !halt_req && !bp_hit (combinational).
  - bp_hit → IDLE, stop_cause=10. The instruction at bp_addr is not executed.
  - halt_req → IDLE, stop_cause=11. halt_req has priority over bp_hit.
- RUN_N: same gating as RUN, plus:
  - remaining decrements on each cycle with cpu_en=1.
  - When remaining==1 and cpu_en=1, next state is IDLE with stop_cause=01.
- DUMP:
  - rf_raddr=dump_idx; dump_data=rf_rdata (combinational); dump_valid=1; cpu_en=0.
  - On dump_valid && dump_ready, dump_idx increments.
  - A transfer at idx 31 → IDLE, stop_cause=01.
  - halt_req → IDLE, stop_cause=11, with no transfer that cycle.
  - dump_data must stay stable while dump_valid && !dump_ready.
- stop_cause: holds its value until the next accepted command, which clears it to 00.
- icount: increments on every cycle with cpu_en=1; 32-bit, wraps 0xFFFFFFFF→0; cleared only by reset.

## Timing
- Reset (rst=0 at an edge): state=IDLE, remaining=0, dump_idx=0, first=0, stop_cause=00, icount=0.
- While rst is low: cpu_en=0, dump_valid=0, busy=0, cmd_ready=0 (forced combinationally).
- Command accepted at edge T: the state is live from cycle T+1.
  - RUN_N N: cpu_en high in cycles T+1..T+N; busy falls and cmd_ready rises in cycle T+N+1.
  - STEP: cpu_en high in T+1 only; cmd_ready high in T+2.
  - DUMP: the first dump_valid is in T+1. With dump_ready held high, 32 transfers occur in T+1..T+32 and cmd_ready is high in T+33.
- Breakpoint or halt: cpu_en is 0 in the same cycle the condition is seen; IDLE follows next cycle.
- Reset asserted mid-RUN or mid-DUMP: cpu_en and dump_valid drop immediately; IDLE after the edge.

## Test plan
- Reset, then RUN_N arg=30 from PC 0x3000 → cpu_en high exactly 30 cycles, icount=30, stop_cause=01, cmd_ready back at T+31.
- STEP ×3 → icount=3, each STEP yields one cpu_en pulse, PC advances 3 instructions.
- bp_en=1, bp_addr=0x300C, RUN from 0x3000 → stops with cpu_pc=0x300C, icount=3, stop_cause=10. A second RUN passes 0x300C without stopping on its first cycle.
- RUN, assert halt_req at cycle 7 after acceptance → cpu_en=0 in that cycle, icount=6, stop_cause=11. halt_req with bp_hit on the same cycle → stop_cause=11.
- DUMP with dump_ready toggling every other cycle → 32 transfers, idx 0..31 in order, data matches the regfile (r0=0), data stable while stalled, completion at T+64 from acceptance.
- RUN_N arg=0 → no cpu_en, stop_cause=01 after 1 cycle. Reset asserted mid-DUMP at idx 10 → dump_valid drops, dump_idx=0 and IDLE after the edge.
